// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial_deser bit-serial deserializer.
package serial_deser_pkg;

    localparam int unsigned       DEF_WORD_W      = 8;
    localparam int unsigned       DEF_SYNC_W      = 8;
    localparam logic [7:0]        DEF_SYNC_PAT    = 8'hA5;
    localparam int unsigned       DEF_FRAME_WORDS = 4;

    localparam logic [0:0] ST_HUNT    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    typedef enum logic [0:0] {
        HUNT    = ST_HUNT,
        COLLECT = ST_COLLECT
    } state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_deser_if.sv
// Word stream handed from serial_deser to its consumer (valid/ready).
interface serial_deser_if
    import serial_deser_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
);
    logic [WORD_W-1:0] word_out;
    logic              valid_out;
    logic              ready_in;

    modport master (output word_out, output valid_out, input ready_in);
    modport slave  (input word_out, input valid_out, output ready_in);
endinterface

// File: rtl/word_fifo2.sv
// Two-entry word FIFO; a push into a full buffer without a same-edge pop is dropped.
module word_fifo2 #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [WORD_W-1:0] head_o
);
    logic [1:0]        count_q, count_d;
    logic [WORD_W-1:0] mem0_q, mem0_d;
    logic [WORD_W-1:0] mem1_q, mem1_d;
    logic              pop_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = empty_o ? '0 : mem0_q;

    always_comb begin
        count_d = count_q;
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        case ({push_i, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) begin
                    mem0_d  = push_data_i;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    mem1_d  = push_data_i;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                mem0_d  = mem1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    mem0_d = push_data_i;
                end else begin
                    mem0_d = mem1_q;
                    mem1_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            count_q <= '0;
            mem0_q  <= '0;
            mem1_q  <= '0;
        end else begin
            count_q <= count_d;
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
        end
    end
endmodule

// File: rtl/serial_deser.sv
// Sync-hunting bit-serial to word deserializer with a 2-entry buffered output.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int unsigned       WORD_W      = DEF_WORD_W,
    parameter int unsigned       SYNC_W      = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT    = DEF_SYNC_PAT,
    parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              enable_in,
    input  logic              din_in,
    output logic              locked_out,
    output logic              frame_done_out,
    output logic              overflow_out,
    serial_deser_if.master    out_if
);
    localparam int unsigned BCW = cnt_w(WORD_W);
    localparam int unsigned WCW = cnt_w(FRAME_WORDS);
    localparam int unsigned HCW = cnt_w(SYNC_W + 1);

    localparam logic [HCW-1:0] HUNT_FULL = HCW'(SYNC_W);
    localparam logic [HCW-1:0] HUNT_LAST = HCW'(SYNC_W - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

    // The oldest sync/data bit is never consulted, so only width-1 bits are stored.
    state_e              state_q, state_d;
    logic [SYNC_W-2:0]   hunt_sr_q, hunt_sr_d;
    logic [HCW-1:0]      hunt_cnt_q, hunt_cnt_d;
    logic [WORD_W-2:0]   data_sr_q, data_sr_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]      word_cnt_q, word_cnt_d;
    logic                frame_done_q, frame_done_d;
    logic                overflow_q, overflow_d;

    logic                bit_ev;
    logic [SYNC_W-1:0]   hunt_next;
    logic [WORD_W-1:0]   word_next;
    logic                push, pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0]   head;

    assign bit_ev    = !enable_in;
    assign hunt_next = {hunt_sr_q, din_in};
    assign word_next = {data_sr_q, din_in};
    assign pop       = !fifo_empty && out_if.ready_in;

    always_comb begin
        state_d      = state_q;
        hunt_sr_d    = hunt_sr_q;
        hunt_cnt_d   = hunt_cnt_q;
        data_sr_d    = data_sr_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
        if (bit_ev) begin
            case (state_q)
                HUNT: begin
                    hunt_sr_d = hunt_next[SYNC_W-2:0];
                    if (hunt_cnt_q != HUNT_FULL) hunt_cnt_d = hunt_cnt_q + HCW'(1);
                    if (hunt_cnt_q >= HUNT_LAST && hunt_next == SYNC_PAT) begin
                        state_d   = COLLECT;
                        bit_cnt_d = '0;
                    end
                end
                COLLECT: begin
                    data_sr_d = word_next[WORD_W-2:0];
                    if (bit_cnt_q == BIT_LAST) begin
                        push      = 1'b1;
                        bit_cnt_d = '0;
                        if (word_cnt_q == WORD_LAST) begin
                            state_d      = HUNT;
                            hunt_sr_d    = '0;
                            hunt_cnt_d   = '0;
                            word_cnt_d   = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + WCW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        overflow_d = overflow_q | (push & fifo_full & !pop);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= HUNT;
            hunt_sr_q    <= '0;
            hunt_cnt_q   <= '0;
            data_sr_q    <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hunt_sr_q    <= hunt_sr_d;
            hunt_cnt_q   <= hunt_cnt_d;
            data_sr_q    <= data_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    word_fifo2 #(.WORD_W(WORD_W)) u_fifo (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .push_i      (push),
        .push_data_i (word_next),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    assign out_if.word_out  = head;
    assign out_if.valid_out = !fifo_empty;
    assign locked_out       = (state_q == COLLECT);
    assign frame_done_out   = frame_done_q;
    assign overflow_out     = overflow_q;
endmodule

// File: tb/tb_serial_deser.sv
// Directed, table-driven bench for serial_deser (8-bit words, sync A5, 4 words/frame).
module tb_serial_deser;

    logic clk_in = 1'b0;
    logic reset_in, enable_in, din_in;
    logic locked_out, frame_done_out, overflow_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    serial_deser_if #(.WORD_W(8)) out_if ();

    serial_deser #(
        .WORD_W      (8),
        .SYNC_W      (8),
        .SYNC_PAT    (8'hA5),
        .FRAME_WORDS (4)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .enable_in      (enable_in),
        .din_in         (din_in),
        .locked_out     (locked_out),
        .frame_done_out (frame_done_out),
        .overflow_out   (overflow_out),
        .out_if         (out_if)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0]  data;
        int unsigned idle;
        logic        rdy;
        logic        e_lock;
        logic        e_valid;
        logic [7:0]  e_word;
        logic        e_fd;
        logic        e_ovf;
    } row_t;

    row_t rows [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic lk, input logic vl,
                             input logic [7:0] wd, input logic fd, input logic ov);
        chk({tag, ".locked"},     32'(locked_out),       32'(lk));
        chk({tag, ".valid"},      32'(out_if.valid_out), 32'(vl));
        chk({tag, ".word"},       32'(out_if.word_out),  32'(wd));
        chk({tag, ".frame_done"}, 32'(frame_done_out),   32'(fd));
        chk({tag, ".overflow"},   32'(overflow_out),     32'(ov));
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // With gap set, each real bit is preceded by a held cycle carrying the inverted bit.
    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            enable_in = 1'b1;
            din_in    = ~b;
            tick();
        end
        enable_in = 1'b0;
        din_in    = b;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap, input int nbits);
        for (int i = 7; i >= 8 - nbits; i--) send_bit(v[i], gap);
    endtask

    task automatic pulse_reset();
        #2 reset_in = 1'b0;
        #2 reset_in = 1'b1;
    endtask

    initial begin
        rows[0]  = '{8'hA5, 0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        rows[1]  = '{8'h01, 0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        rows[2]  = '{8'h02, 0, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0};
        rows[3]  = '{8'h03, 0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        rows[4]  = '{8'h04, 0, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0};
        rows[5]  = '{8'h05, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        rows[6]  = '{8'hA5, 0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        rows[7]  = '{8'h06, 0, 1'b1, 1'b1, 1'b1, 8'h06, 1'b0, 1'b0};
        rows[8]  = '{8'h11, 1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        rows[9]  = '{8'h22, 0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        rows[10] = '{8'h33, 0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1};

        reset_in         = 1'b0;
        enable_in        = 1'b0;
        din_in           = 1'b0;
        out_if.ready_in  = 1'b1;

        for (int c = 0; c < 3; c++) begin
            din_in = 1'($urandom);
            tick();
            check_all("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        enable_in = 1'b1;
        reset_in  = 1'b1;
        tick();

        // Lock, frame end, relock, then backpressure into overflow
        for (int r = 0; r < 11; r++) begin
            out_if.ready_in = 1'b1;
            enable_in       = 1'b1;
            for (int k = 0; k < int'(rows[r].idle); k++) begin
                din_in = 1'($urandom);
                tick();
            end
            out_if.ready_in = rows[r].rdy;
            send_byte(rows[r].data, 1'b0, 8);
            enable_in = 1'b1;
            check_all($sformatf("row%0d", r), rows[r].e_lock, rows[r].e_valid,
                      rows[r].e_word, rows[r].e_fd, rows[r].e_ovf);
        end

        out_if.ready_in = 1'b1;
        tick();
        check_all("drain1", 1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
        tick();
        check_all("drain2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset between clock edges
        send_byte(8'hA5, 1'b0, 8);
        enable_in = 1'b1;
        check_all("prelock", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        #3 reset_in = 1'b0;
        #1 check_all("async_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset_in = 1'b1;

        // Reset mid-COLLECT discards the partial word and forces a full relock
        send_byte(8'hA5, 1'b0, 8);
        chk("midrst.lock", 32'(locked_out), 32'd1);
        send_byte(8'h3C, 1'b0, 4);
        #2 reset_in = 1'b0;
        #1 check_all("midrst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1 reset_in = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        check_all("midrst_tail", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 7);
        chk("relock7", 32'(locked_out), 32'd0);
        send_bit(1'b1, 1'b0);
        chk("relock8", 32'(locked_out), 32'd1);
        send_byte(8'h77, 1'b0, 8);
        enable_in = 1'b1;
        check_all("relock_word", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);

        // Qualifier gaps with a near-miss sync word
        pulse_reset();
        send_byte(8'hA4, 1'b1, 8);
        chk("gap.A4", 32'(locked_out), 32'd0);
        send_byte(8'hA5, 1'b1, 8);
        chk("gap.A5", 32'(locked_out), 32'd1);
        send_byte(8'h3C, 1'b1, 8);
        enable_in = 1'b1;
        check_all("gap.3C", 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        tick();
        check_all("gap.after", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_deser.md
Name: serial_deser

Overview:
- Bit-serial to word deserializer that sits directly downstream of the dff capture stage.
- Consumes the registered serial bit stream and its active-low qualifier, hunts for a sync pattern, then assembles FRAME_WORDS words of WORD_W bits, MSB first.
- Hands each word to the consumer through a 2-entry buffered valid/ready interface.

Parameters:
- WORD_W, 8, data word width in bits (>=2).
- SYNC_W, 8, sync pattern width in bits (>=2).
- SYNC_PAT, 8'hA5, sync pattern; the first received bit is compared against the MSB.
- FRAME_WORDS, 4, words collected per sync before hunting again (>=1).

Ports:
- clk_in, input, 1, single clock; all state updates on its rising edge.
- reset_in, input, 1, asynchronous active-low reset.
- enable_in, input, 1, active-low bit qualifier; din_in is sampled on a rising edge only when enable_in==0.
- din_in, input, 1, serial data bit (the upstream dff q output).
- ready_in, input, 1, consumer ready.
- word_out, output, WORD_W, head-of-buffer word.
- valid_out, output, 1, word_out is valid.
- locked_out, output, 1, high while in COLLECT.
- frame_done_out, output, 1, one-cycle pulse when the last word of a frame is captured.
- overflow_out, output, 1, sticky; set when a word is dropped.

Behaviour:
- Reset (reset_in==0, asynchronous, takes effect immediately and at any point mid-operation):
  - State goes to HUNT; hunt shift register, hunt bit count, bit count, word count and buffer are cleared.
  - word_out=0, valid_out=0, locked_out=0, frame_done_out=0, overflow_out=0.
- Bit event: a rising edge with enable_in==0. On edges with enable_in==1 all shift registers and counters hold.
- HUNT state:
  - Each bit event shifts din_in into the LSB of the SYNC_W hunt register; the hunt bit count saturates at SYNC_W.
  - Match = {hunt_sr[SYNC_W-2:0], din_in} == SYNC_PAT, qualified only once at least SYNC_W bits have arrived since entering HUNT (the current bit included).
  - On a match, go to COLLECT. locked_out rises the cycle after the edge carrying the last sync bit.
  - Non-matching bits keep sliding, so overlapping patterns are detected.
- COLLECT state:
  - Each bit event shifts din_in into the LSB of the data shift register and increments the bit count.
  - On the WORD_W-th bit, word = {data_sr[WORD_W-2:0], din_in} is pushed into the buffer on that same edge. The bit count resets to 0 and the word count increments.
  - If the pushed word is word FRAME_WORDS-1 (zero-based):
    - frame_done_out=1 for the following cycle only.
    - Go to HUNT; locked_out falls the same cycle.
    - Hunt register and hunt bit count are cleared and the word count is reset.
  - Sync bits are never emitted as data.
- Output buffer, 2-entry FIFO:
  - Pop when valid_out && ready_in.
  - valid_out = buffer non-empty; word_out = head entry, and holds 0 when empty.
  - Latency: a word pushed into an empty buffer appears on word_out/valid_out the cycle after the push edge.
  - Push and pop on the same edge:
    - Full buffer: both happen and the occupancy stays 2.
    - Empty buffer: the push only (no pop is possible).
  - Push when full and no pop: the new word is dropped, the buffer contents are unchanged, and overflow_out is set to 1.
  - A dropped word still counts toward FRAME_WORDS.
  - overflow_out clears only on reset.
- word_out/valid_out are stable while valid_out && !ready_in.
- Buffered words survive the return to HUNT and continue to drain.

Decomposition:
- serial_deser_pkg:
  - state enum {HUNT, COLLECT};
  - default constants for WORD_W, SYNC_W, SYNC_PAT, FRAME_WORDS;
  - localparam helpers for counter widths ($clog2(WORD_W), $clog2(FRAME_WORDS), $clog2(SYNC_W+1)).
- Sub-module word_fifo2:
  - 2-entry, WORD_W-wide FIFO with push, pop, full, empty and head outputs;
  - same clk_in/reset_in;
  - holds the drop-on-full policy; serial_deser itself sets overflow_out.

Test Plan (WORD_W=8, SYNC_W=8, SYNC_PAT=8'hA5, FRAME_WORDS=4, MSB first):
- Reset: hold reset_in=0 for 3 cycles with random din_in -> all outputs 0. Assert reset_in=0 asynchronously mid-cycle -> outputs go to 0 without waiting for a clock edge.
- Lock and capture: enable_in=0 every cycle, ready_in=1, send A5 then 3C -> locked_out=1 the cycle after the 8th sync bit. word_out=8'h3C with valid_out=1 for exactly one cycle, starting the cycle after the 8th data bit.
- Qualifier gaps and false sync: send A4 A5 3C with enable_in=1 on every other cycle -> no lock after A4; lock after A5; word_out=8'h3C. Held bits are not duplicated.
- Backpressure/overflow: ready_in=0, after lock send 11 22 33 -> buffer holds 11 and 22; 33 is dropped; overflow_out=1. Then set ready_in=1 -> 8'h11 then 8'h22, one per cycle; overflow_out stays 1.
- Frame end: send A5 + 01 02 03 04 + 05 -> frame_done_out pulses once after 04, and locked_out=0 from that cycle. 05 is never emitted. A following A5 + 06 yields word_out=8'h06.
- Reset mid-COLLECT: after lock plus 4 data bits, pulse reset_in=0 -> locked_out=0 and valid_out=0. The remaining 4 bits produce no word. A full A5 is required to relock.
